// File: rtl/shift_add_mult_if.sv
// Operand/result bundle for the sequential shift-add multiplier.
interface shift_add_mult_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               ready;

  modport master (
    output start, signed_mode, a, b,
    input  product, busy, ready
  );

  modport slave (
    input  start, signed_mode, a, b,
    output product, busy, ready
  );
endinterface

// File: rtl/shift_add_mult.sv
// Radix-2 shift-add multiplier: one ADD and one SHIFT cycle per multiplier bit,
// signed operands handled as sign-magnitude with a final negate (FIX) step.
module shift_add_mult #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic            clock,
  input  logic            n_rst,
  shift_add_mult_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD   = 3'd1,
    SHIFT = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             r_state, w_state_next;
  logic [WIDTH:0]     r_acc, w_acc_next;
  logic [WIDTH-1:0]   r_q, w_q_next;
  logic [WIDTH-1:0]   r_m, w_m_next;
  logic [CNT_W-1:0]   r_count, w_count_next;
  logic               r_neg, w_neg_next;
  logic               r_signed, w_signed_next;
  logic [2*WIDTH-1:0] r_product;
  logic               w_load_product;

  logic               w_signed_in;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_low;
  logic [2*WIDTH-1:0] w_low_neg;

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is exact unsigned.
  assign w_signed_in = SIGNED_EN && bus.signed_mode;
  assign w_a_mag     = (w_signed_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_b_mag     = (w_signed_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign w_low       = {r_acc[WIDTH-1:0], r_q};
  assign w_low_neg   = -w_low;

  always_comb begin
    w_state_next   = r_state;
    w_acc_next     = r_acc;
    w_q_next       = r_q;
    w_m_next       = r_m;
    w_count_next   = r_count;
    w_neg_next     = r_neg;
    w_signed_next  = r_signed;
    w_load_product = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_m_next      = w_a_mag;
          w_q_next      = w_b_mag;
          w_acc_next    = '0;
          w_count_next  = CNT_LOAD;
          w_signed_next = w_signed_in;
          w_neg_next    = w_signed_in && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          w_state_next  = ADD;
        end
      end
      ADD: begin
        if (r_q[0]) begin
          w_acc_next = r_acc + {1'b0, r_m};
        end
        w_count_next = (r_count != CNT_ZERO) ? r_count - CNT_ONE : CNT_ZERO;
        w_state_next = SHIFT;
      end
      SHIFT: begin
        {w_acc_next, w_q_next} = {r_acc, r_q} >> 1;
        if (r_count != CNT_ZERO) begin
          w_state_next = ADD;
        end else if (r_signed) begin
          w_state_next = FIX;
        end else begin
          w_state_next   = DONE;
          w_load_product = 1'b1;
        end
      end
      FIX: begin
        if (r_neg) begin
          {w_acc_next, w_q_next} = {1'b0, w_low_neg};
        end
        w_state_next   = DONE;
        w_load_product = 1'b1;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_count   <= '0;
      r_neg     <= 1'b0;
      r_signed  <= 1'b0;
      r_product <= '0;
    end else begin
      r_state  <= w_state_next;
      r_acc    <= w_acc_next;
      r_q      <= w_q_next;
      r_m      <= w_m_next;
      r_count  <= w_count_next;
      r_neg    <= w_neg_next;
      r_signed <= w_signed_next;
      // Result only moves on the edge that enters DONE.
      if (w_load_product) begin
        r_product <= {w_acc_next[WIDTH-1:0], w_q_next};
      end
    end
  end

  assign bus.product = r_product;
  assign bus.busy    = (r_state == ADD) || (r_state == SHIFT) || (r_state == FIX);
  assign bus.ready   = (r_state == DONE);
endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult (WIDTH=8, SIGNED_EN=1): vector table plus
// busy-protection, DONE hold / back-to-back and mid-operation reset sequences.
module tb_shift_add_mult;
  localparam int W = 8;

  logic clock = 1'b0;
  logic n_rst = 1'b0;

  shift_add_mult_if #(.WIDTH(W)) bus ();

  shift_add_mult #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clock (clock),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sm;
    logic [2*W-1:0] p;
    int             lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Latency is counted in the spec's sense: the value of ready as sampled at
  // edge k+lat, where edge k samples start. Sampling happens on falling edges.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsm,
                        input logic [2*W-1:0] exp, input int lat, input string name);
    int idx;
    logic [2*W-1:0] prev;
    @(negedge clock);
    prev            = bus.product;
    bus.start       = 1'b1;
    bus.a           = ta;
    bus.b           = tb_v;
    bus.signed_mode = tsm;
    @(negedge clock);
    bus.start       = 1'b0;
    bus.a           = ~ta;
    bus.b           = tb_v ^ 8'h5A;
    bus.signed_mode = ~tsm;
    check({name, " busy_at_start"}, {31'd0, bus.busy}, 32'd1);
    check({name, " ready_drops"}, {31'd0, bus.ready}, 32'd0);
    check({name, " product_held"}, {16'd0, bus.product}, {16'd0, prev});
    idx = 0;
    while (!bus.ready && idx < 40) begin
      @(negedge clock);
      idx++;
    end
    check({name, " latency"}, idx + 1, lat);
    check({name, " product"}, {16'd0, bus.product}, {16'd0, exp});
    check({name, " busy_done"}, {31'd0, bus.busy}, 32'd0);
    $display("op %s a=%02h b=%02h signed=%0b product=%04h latency=%0d",
             name, ta, tb_v, tsm, bus.product, idx + 1);
  endtask

  initial begin
    int idx;
    vecs[0] = '{8'd13,  8'd11,  1'b0, 16'd143,  17};
    vecs[1] = '{8'd255, 8'd255, 1'b0, 16'hFE01, 17};
    vecs[2] = '{8'd0,   8'd200, 1'b0, 16'd0,    17};
    vecs[3] = '{8'hFD,  8'd5,   1'b1, 16'hFFF1, 18};
    vecs[4] = '{8'h80,  8'h80,  1'b1, 16'h4000, 18};
    vecs[5] = '{8'hFF,  8'hFF,  1'b1, 16'h0001, 18};
    vecs[6] = '{8'h7F,  8'h80,  1'b1, 16'hC080, 18};
    vecs[7] = '{8'hFD,  8'd5,   1'b0, 16'h04F1, 17};
    vecs[8] = '{8'h80,  8'h01,  1'b1, 16'hFF80, 18};
    vecs[9] = '{8'h01,  8'hFF,  1'b1, 16'hFFFF, 18};

    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a           = '0;
    bus.b           = '0;

    #1;
    check("reset product", {16'd0, bus.product}, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset ready", {31'd0, bus.ready}, 32'd0);
    repeat (3) @(negedge clock);
    n_rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].p, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Second start at edge k+5 with other operands must be ignored.
    @(negedge clock);
    bus.start = 1'b1; bus.a = 8'd13; bus.b = 8'd11; bus.signed_mode = 1'b0;
    @(negedge clock);
    bus.start = 1'b0;
    idx = 0;
    repeat (4) begin
      @(negedge clock);
      idx++;
    end
    bus.start = 1'b1; bus.a = 8'd99; bus.b = 8'd77; bus.signed_mode = 1'b1;
    @(negedge clock);
    idx++;
    bus.start = 1'b0;
    check("busyprot busy", {31'd0, bus.busy}, 32'd1);
    while (!bus.ready && idx < 40) begin
      @(negedge clock);
      idx++;
    end
    check("busyprot latency", idx + 1, 32'd17);
    check("busyprot product", {16'd0, bus.product}, 32'd143);
    $display("op busyprot a=0d b=0b product=%04h latency=%0d", bus.product, idx + 1);

    // DONE holds its result until the next start.
    repeat (3) @(negedge clock);
    check("hold ready", {31'd0, bus.ready}, 32'd1);
    check("hold product", {16'd0, bus.product}, 32'd143);

    // Back-to-back from DONE.
    run_op(8'd2, 8'd3, 1'b0, 16'd6, 17, "b2b");

    // Reset mid-operation.
    @(negedge clock);
    bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd100; bus.signed_mode = 1'b0;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (6) @(negedge clock);
    n_rst = 1'b0;
    #1;
    check("midreset busy", {31'd0, bus.busy}, 32'd0);
    check("midreset ready", {31'd0, bus.ready}, 32'd0);
    check("midreset product", {16'd0, bus.product}, 32'd0);
    @(negedge clock);
    n_rst = 1'b1;
    repeat (20) @(negedge clock);
    check("postreset ready", {31'd0, bus.ready}, 32'd0);
    check("postreset product", {16'd0, bus.product}, 32'd0);
    $display("op midreset a=c8 b=64 aborted product=%04h", bus.product);

    run_op(8'd2, 8'd3, 1'b0, 16'd6, 17, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
